// File: rtl/uart_pkg.sv
// Shared types and default sizing for the UART transmit-side arbiter.
package uart_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_MAX_BURST = 4;

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_START     = 2'd1,
    ARB_WAIT_DONE = 2'd2
  } tx_arb_state_t;

endpackage

// File: rtl/tx_arbiter_if.sv
// Requester and transmitter signals of tx_arbiter bundled with master (arbiter)
// and slave (requesters + transmitter) views.
interface tx_arbiter_if #(
  parameter int NUM_REQ = uart_pkg::DEF_NUM_REQ
);
  import uart_pkg::*;

  localparam int IDX_W = $clog2(NUM_REQ);

  // Handshake: req[i] acts as valid and must stay high with req_data[i] stable
  // until ack[i] pulses; the arbiter only grants in IDLE while tx_ready is high,
  // then tx_start launches the latched byte and tx_done closes the grant.
  logic [NUM_REQ-1:0]        req;
  byte_t [NUM_REQ-1:0]       req_data;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        ack;
  logic                      tx_ready;
  logic                      tx_done;
  logic                      tx_start;
  byte_t                     tx_data;
  logic [IDX_W-1:0]          owner;
  logic                      busy;
  tx_arb_state_t             dbg_state;

  modport master (
    input  req, req_data, req_lock, tx_ready, tx_done,
    output ack, tx_start, tx_data, owner, busy, dbg_state
  );

  modport slave (
    output req, req_data, req_lock, tx_ready, tx_done,
    input  ack, tx_start, tx_data, owner, busy, dbg_state
  );

endinterface

// File: rtl/rr_priority_select.sv
// Combinational rotating-priority search: first set req bit at or above rr_ptr, with wrap.
module rr_priority_select #(
  parameter  int NUM_REQ = uart_pkg::DEF_NUM_REQ,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   index
);

  localparam logic [IDX_W:0] N_W = (IDX_W+1)'(NUM_REQ);

  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the closest hit is the last write.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (cand >= N_W) cand = cand - N_W;
      if (req[cand[IDX_W-1:0]]) begin
        valid = 1'b1;
        index = cand[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Round-robin byte arbiter feeding one UART transmitter.
// Burst locking of a grant is compiled in only when TX_ARB_BURST_LOCK_EN is defined.
module tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input logic          clk,
  input logic          rst,
  tx_arbiter_if.master bus
);

  localparam int                 IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  tx_arb_state_t      state_q;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   owner_q;
  byte_t              tx_data_q;
  logic               tx_start_q;
  logic [NUM_REQ-1:0] ack_q;

  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   rr_ptr_d;
  logic               burst_go;

  rr_priority_select #(.NUM_REQ(NUM_REQ)) u_select (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .valid  (pick_valid),
    .index  (pick_idx)
  );

  assign rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;

`ifdef TX_ARB_BURST_LOCK_EN
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);
  logic [3:0] burst_cnt_q;

  assign burst_go = bus.req[owner_q] & bus.req_lock[owner_q] & bus.tx_ready &
                    (burst_cnt_q < BURST_LAST);
`else
  logic unused_lock;
  assign unused_lock = ^{bus.req_lock, 4'(MAX_BURST)};
  assign burst_go    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      ack_q      <= '0;
`ifdef TX_ARB_BURST_LOCK_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      ack_q      <= '0;
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid && bus.tx_ready) begin
            owner_q    <= pick_idx;
            tx_data_q  <= bus.req_data[pick_idx];
            tx_start_q <= 1'b1;
            ack_q      <= ONE_HOT0 << pick_idx;
            state_q    <= ARB_START;
`ifdef TX_ARB_BURST_LOCK_EN
            burst_cnt_q <= '0;
`endif
          end
        end
        ARB_START: state_q <= ARB_WAIT_DONE;
        ARB_WAIT_DONE: begin
          if (bus.tx_done) begin
            if (burst_go) begin
              // Locked owner keeps the transmitter; rr_ptr stays put.
              tx_data_q  <= bus.req_data[owner_q];
              tx_start_q <= 1'b1;
              ack_q      <= ONE_HOT0 << owner_q;
              state_q    <= ARB_START;
`ifdef TX_ARB_BURST_LOCK_EN
              burst_cnt_q <= burst_cnt_q + 1'b1;
`endif
            end else begin
              rr_ptr_q <= rr_ptr_d;
              state_q  <= ARB_IDLE;
            end
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.tx_start  = tx_start_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != ARB_IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Bench for tx_arbiter: directed scenarios with an expected-grant queue plus a
// randomized run, all checked every cycle against a transaction-level model.
module tb_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;
`ifdef TX_ARB_BURST_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tx_arbiter_if #(.NUM_REQ(N)) bus ();

  tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [$clog2(N)-1:0] exp_q[$];

  // reference model, advanced once per clock from the inputs the DUT will sample
  int         m_phase = 0;   // 0 idle, 1 launching, 2 waiting for transmitter
  int         m_owner = 0;
  int         m_ptr   = 0;
  int         m_burst = 0;
  logic [7:0] m_data  = 8'h00;
  bit         m_valid = 1'b0;

  // stimulus environment state
  int mode        = 1;       // 0 random requesters, 1 hold, 2 drop on ack
  bit rand_tx     = 1'b0;
  bit idle_ready  = 1'b1;
  bit tx_busy     = 1'b0;
  int tx_cnt      = 0;
  int lat         = 3;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_ptr = 0; m_owner = 0; m_burst = 0; m_data = 8'h00;
    end else if (m_phase == 0) begin
      if (bus.req != '0 && bus.tx_ready) begin
        for (int k = 0; k < N; k++) begin
          if (bus.req[(m_ptr + k) % N]) begin
            m_owner = (m_ptr + k) % N;
            break;
          end
        end
        m_data  = bus.req_data[m_owner];
        m_burst = 0;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (bus.tx_done) begin
      if (LOCK_EN && bus.req[m_owner] && bus.req_lock[m_owner] && bus.tx_ready && m_burst < MB - 1) begin
        m_data  = bus.req_data[m_owner];
        m_burst = m_burst + 1;
        m_phase = 1;
      end else begin
        m_ptr   = (m_owner + 1) % N;
        m_phase = 0;
      end
    end
  endtask

  // scoreboard / compare process
  always @(negedge clk) begin
    logic [$clog2(N)-1:0] e;
    if (m_valid) begin
      check("tx_start", bus.tx_start, m_phase == 1);
      check("ack", bus.ack, (m_phase == 1) ? (32'd1 << m_owner) : 32'd0);
      check("tx_data", bus.tx_data, m_data);
      check("owner", bus.owner, m_owner);
      check("busy", bus.busy, m_phase != 0);
      if (bus.tx_start && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("grant_order", bus.owner, e);
        check("model_grant", m_owner, e);
      end
    end
    model_step();
    m_valid = 1'b1;
  end

  // driver: one clock of transmitter and requester behaviour
  task automatic step();
    @(posedge clk);
    #1;
    bus.tx_done = 1'b0;
    if (bus.tx_start) begin
      tx_busy      = 1'b1;
      tx_cnt       = rand_tx ? $urandom_range(1, 6) : lat;
      bus.tx_ready = 1'b0;
    end else if (tx_busy) begin
      tx_cnt--;
      if (tx_cnt == 0) begin
        tx_busy      = 1'b0;
        bus.tx_done  = 1'b1;
        bus.tx_ready = rand_tx ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end else begin
      bus.tx_ready = rand_tx ? ($urandom_range(0, 5) != 0) : idle_ready;
      if (rand_tx && !bus.busy && $urandom_range(0, 15) == 0) bus.tx_done = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        if (bus.ack[i]) begin
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
          else begin
            bus.req_data[i] = 8'($urandom);
            bus.req_lock[i] = 1'($urandom_range(0, 1));
          end
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i]      = 1'b1;
          bus.req_data[i] = 8'($urandom);
          bus.req_lock[i] = 1'($urandom_range(0, 1));
        end
      end else if (mode == 2 && bus.ack[i]) begin
        bus.req[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    bus.req      = '0;
    bus.req_lock = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_grants(input string name, input int bound);
    int c = 0;
    while (exp_q.size() != 0 && c < bound) begin
      step();
      c++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_idle(input string name, input int bound);
    int c = 0;
    while ((bus.busy || tx_busy) && c < bound) begin
      step();
      c++;
    end
    check(name, (bus.busy || tx_busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, passed %0d of %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req      = '0;
    bus.req_data = '0;
    bus.req_lock = '0;
    bus.tx_ready = 1'b1;
    bus.tx_done  = 1'b0;
    step();
    step();
    step();
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_owner", bus.owner, 0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_ack", bus.ack, 0);
    check("rst_tx_start", bus.tx_start, 0);

    // single request from requester 2
    mode = 2;
    bus.req_data[2] = 8'hA5;
    bus.req = 4'b0100;
    exp_q.push_back(2);
    step();
    check("single_start", bus.tx_start, 1);
    check("single_ack", bus.ack, 4'b0100);
    check("single_data", bus.tx_data, 8'hA5);
    check("single_owner", bus.owner, 2);
    wait_grants("single_timeout", 50);
    wait_idle("single_idle", 50);

    // fairness with all requesters held
    do_reset();
    mode = 1;
    lat  = 10;
    for (int i = 0; i < N; i++) bus.req_data[i] = 8'h10 + 8'(i);
    bus.req = 4'b1111;
    exp_q = '{0, 1, 2, 3, 0};
    wait_grants("fair_timeout", 400);
    bus.req = '0;
    wait_idle("fair_idle", 100);

    // wrap: owner 3 released, then requesters 0 and 3 compete
    do_reset();
    mode = 2;
    lat  = 3;
    bus.req = 4'b1111;
    exp_q = '{0, 1, 2, 3};
    wait_grants("wrap_pass1_timeout", 200);
    wait_idle("wrap_idle1", 50);
    bus.req = 4'b1001;
    exp_q = '{0, 3};
    wait_grants("wrap_timeout", 100);
    wait_idle("wrap_idle2", 50);

    // burst lock on requester 1 with requester 0 waiting
    do_reset();
    mode = 1;
    bus.req_data[1] = 8'h5A;
    bus.req_lock    = 4'b0010;
    bus.req         = 4'b0010;
`ifdef TX_ARB_BURST_LOCK_EN
    exp_q = '{1, 1, 1, 1, 0};
`else
    exp_q = '{1, 0, 1, 0};
`endif
    step();
    bus.req_data[0] = 8'hC3;
    bus.req[0]      = 1'b1;
    wait_grants("lock_timeout", 300);
    bus.req      = '0;
    bus.req_lock = '0;
    wait_idle("lock_idle", 100);

    // stall with tx_ready low, then spurious tx_done in IDLE
    do_reset();
    idle_ready   = 1'b0;
    bus.tx_ready = 1'b0;
    bus.req      = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      step();
      check("stall_busy", bus.busy, 0);
      check("stall_start", bus.tx_start, 0);
    end
    bus.req      = '0;
    idle_ready   = 1'b1;
    bus.tx_ready = 1'b1;
    bus.tx_done  = 1'b1;
    step();
    step();
    check("spurious_busy", bus.busy, 0);
    check("spurious_owner", bus.owner, 0);

    // reset while owner 1 waits for tx_done
    do_reset();
    mode = 1;
    lat  = 8;
    bus.req = 4'b1111;
    exp_q = '{0, 1};
    wait_grants("rstmid_pre_timeout", 100);
    check("rstmid_pre_busy", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_busy", bus.busy, 0);
    check("rstmid_start", bus.tx_start, 0);
    check("rstmid_ack", bus.ack, 0);
    exp_q = '{0};
    wait_grants("rstmid_regrant_timeout", 100);
    bus.req = '0;
    wait_idle("rstmid_idle", 100);

    // randomized traffic
    do_reset();
    mode    = 0;
    rand_tx = 1'b1;
    repeat (3000) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
